// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate multiply-accumulate datapath.
// Holds the MAC state encoding, operand/product widths and the saturation ceiling.
package approx_mult_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } mac_state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            last;
  } beat_t;

  // Largest value representable in w bits (w in 1..32).
  function automatic logic [31:0] sat_max(input int unsigned w);
    logic [31:0] all_ones;
    all_ones = '1;
    return all_ones >> (32 - w);
  endfunction

endpackage

// File: rtl/approx_mult_8x8.sv
// 8x8 approximate multiplier: the two cross nibble products are merged with a
// bitwise OR instead of an add, trading accuracy for a shorter carry chain.
module approx_mult_8x8
  import approx_mult_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  localparam int unsigned PP_W = 2 * NIB_W;

  logic [NIB_W-1:0] al, ah, bl, bh;
  logic [PP_W-1:0]  pp_ll, pp_lh, pp_hl, pp_hh, pp_mid;

  assign al = a[NIB_W-1:0];
  assign ah = a[OP_W-1:NIB_W];
  assign bl = b[NIB_W-1:0];
  assign bh = b[OP_W-1:NIB_W];

  always_comb begin
    pp_ll  = PP_W'(al) * PP_W'(bl);
    pp_lh  = PP_W'(al) * PP_W'(bh);
    pp_hl  = PP_W'(ah) * PP_W'(bl);
    pp_hh  = PP_W'(ah) * PP_W'(bh);
    pp_mid = pp_lh | pp_hl;
    p      = {pp_hh, PP_W'(0)}
           + PROD_W'({pp_mid, NIB_W'(0)})
           + PROD_W'(pp_ll);
  end

endmodule

// File: rtl/approx_mac_8x8.sv
// Three-stage approximate multiply-accumulate: operand register, product register,
// saturating accumulator; a frame result is held until downstream takes it.
module approx_mac_8x8
  import approx_mult_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int unsigned      SUM_W   = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mac_state_t state, state_nxt;

  logic              xfer;
  logic              s1_valid;
  beat_t             s1_beat;
  logic [PROD_W-1:0] prod;
  logic              s2_valid;
  logic              s2_last;
  logic [PROD_W-1:0] s2_prod;
  logic [ACC_W-1:0]  acc_q;
  logic              sat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SUM_W-1:0]  add_sum;
  logic [ACC_W-1:0]  acc_add;
  logic              sat_add;
  logic [CNT_W-1:0]  cnt_add;
  logic              last_add;
  logic              res_take;

  assign xfer     = in_valid & in_ready;
  assign last_add = s2_valid & s2_last;
  assign res_take = out_valid & out_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:   if (xfer && in_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_add)        state_nxt = ST_HOLD;
      ST_HOLD:  if (res_take)        state_nxt = ST_ACC;
      default:                       state_nxt = ST_ACC;
    endcase
  end

  // FSM outputs; gated by rst_n so nothing is offered while reset is held
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && (state == ST_ACC)) in_ready = 1'b1;
  end

  // Stage 1: capture accepted operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_beat  <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_beat.a    <= in_a;
        s1_beat.b    <= in_b;
        s1_beat.last <= in_last;
      end
    end
  end

  approx_mult_8x8 u_mult (
    .a (s1_beat.a),
    .b (s1_beat.b),
    .p (prod)
  );

  // Stage 2: register the approximate product
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= prod;
        s2_last <= s1_beat.last;
      end
    end
  end

  // Saturating add; the carry out of the widened sum flags a clipped add
  always_comb begin
    add_sum = SUM_W'(acc_q) + SUM_W'(s2_prod);
    acc_add = add_sum[ACC_W] ? ACC_MAX : add_sum[ACC_W-1:0];
    sat_add = sat_q | add_sum[ACC_W];
    cnt_add = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Stage 3: accumulator, sticky saturation and beat counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else if (res_take) begin
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else if (s2_valid) begin
      acc_q <= acc_add;
      sat_q <= sat_add;
      cnt_q <= cnt_add;
    end
  end

  // Result registers load on the same edge the final beat is accumulated
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
      out_cnt   <= '0;
    end else if (last_add) begin
      out_valid <= 1'b1;
      out_acc   <= acc_add;
      out_sat   <= sat_add;
      out_cnt   <= cnt_add;
    end else if (res_take) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/approx_mac_8x8.md
APPROX_MAC_8X8 -- requirements
Module: approx_mac_8x8

Interface
REQ-001 SHALL have parameter ACC_W, default 24: accumulator/result width, legal range 16..32.
REQ-002 SHALL have parameter CNT_W, default 8: beat-counter width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_a  input  8  multiplicand.
REQ-008 in_b  input  8  multiplier.
REQ-009 in_last  input  1  marks final beat of a frame.
REQ-010 out_valid  output  1  frame result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_acc  output  ACC_W  saturated sum of approximate products of the frame.
REQ-013 out_sat  output  1  sticky flag: saturation occurred in this frame.
REQ-014 out_cnt  output  CNT_W  beats in frame, saturating at all-ones.

Function
REQ-015 A beat SHALL transfer on a rising edge where in_valid and in_ready are both 1; the block SHALL ignore in_a, in_b and in_last at all other times.
REQ-016 Stage 1 SHALL register in_a, in_b, in_last and a valid bit on transfer.
REQ-017 Products SHALL come from the team's 8x8 approximate multiplier (OR-compressed 4x4 partial products) driven from stage-1 registers; its 16-bit output SHALL be registered in stage 2 with valid and last.
REQ-018 Stage 3 SHALL add the zero-extended stage-2 product into the accumulator when stage-2 valid is 1.
REQ-019 The add SHALL saturate at 2^ACC_W-1; any clipped add SHALL set the sticky sat bit.
REQ-020 The beat counter SHALL increment on each stage-3 add and hold at all-ones.
REQ-021 FSM states: ACC, DRAIN, HOLD; reset state ACC.
REQ-022 in_ready SHALL be 1 only in ACC.
REQ-023 ACC->DRAIN on transfer with in_last=1; no further beats are accepted.
REQ-024 DRAIN->HOLD on the edge where the last-marked beat is added in stage 3; out_acc, out_sat and out_cnt SHALL be loaded into output registers and out_valid set on that edge.
REQ-025 Latency SHALL be exactly 3 rising edges from last-beat transfer to out_valid=1.
REQ-026 In HOLD, outputs SHALL stay stable until out_valid and out_ready are both 1 on an edge; that edge SHALL clear out_valid, clear the accumulator, the sat bit and the counter, and return to ACC.
REQ-027 in_ready SHALL be 1 on the cycle after the result handshake; no beat is accepted in the handshake cycle itself.
REQ-028 A single-beat frame (first beat carries in_last) SHALL produce out_cnt=1.
REQ-029 in_valid=0 gaps inside a frame SHALL insert pipeline bubbles only and SHALL NOT change the result.
REQ-030 out_ready=1 outside HOLD SHALL have no effect.

Reset
REQ-031 On rst_n=0, all of the following SHALL reset on the next edge, regardless of state and with in-flight beats discarded:
- FSM to ACC
- all stage valid bits to 0
- accumulator, sat bit and counter to 0
- out_valid=0, out_acc=0, out_sat=0, out_cnt=0
REQ-032 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first cycle after rst_n returns to 1.

Structure
REQ-033 The FSM state encoding and the saturation-max constant function SHALL live in the shared package approx_mult_pkg.
REQ-034 The only sub-module SHALL be the existing 8x8 approximate multiplier, instantiated once; the pipeline, FSM and accumulator are in approx_mac_8x8 itself.

Verification
REQ-035 Reset then 4 beats of a=0x01, b=0x01 with last on beat 4 -> out_acc=4, out_cnt=4, out_sat=0, out_valid exactly 3 edges after beat 4.
REQ-036 ACC_W=16, single beat a=0x00, b=0xFF, last=1 -> out_acc=0, out_cnt=1.
REQ-037 ACC_W=16, 300 beats of a=0xFF, b=0xFF -> out_sat=1, out_acc=0xFFFF, out_cnt=0xFF.
REQ-038 Hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; out_ready=1 -> next frame starts from acc=0.
REQ-039 Assert rst_n=0 mid-frame after 2 beats, then send 1 beat a=0x01, b=0x01, last=1 -> out_acc=1, out_cnt=1.
REQ-040 Random frames with random in_valid gaps and out_ready stalls -> every result matches a scoreboard built from the multiplier's own output, summed with saturation.
